// File: rtl/adder_operand_feeder_pkg.sv
// adder_operand_feeder_pkg: shared sizes, Mm layout and FSM encodings for the adder operand feeder
package adder_operand_feeder_pkg;
    localparam int N_OPS     = 8;
    localparam int NIB_W     = 4;
    localparam int LANE_W    = 8;
    localparam int ADDER_LAT = 2;
    localparam int SUM_W     = 8;
    localparam int BUS_W     = N_OPS * LANE_W;
    localparam int IDX_W     = $clog2(N_OPS);
    localparam int CNT_W     = $clog2(ADDER_LAT + 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [2:0] big_m;
        logic [2:0] small_m;
    } mm_t;

    function automatic logic [LANE_W-1:0] lane_of(input logic [NIB_W-1:0] nib);
        return {{(LANE_W - NIB_W){1'b0}}, nib};
    endfunction
endpackage

// File: rtl/adder_operand_feeder_if.sv
// adder_operand_feeder_if: operand stream, adder lane bus and result stream of the feeder
interface adder_operand_feeder_if;
    import adder_operand_feeder_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [NIB_W-1:0]  in_nib;
    mm_t               in_Mm;
    logic              flush;
    logic [BUS_W-1:0]  add_data;
    mm_t               add_Mm;
    logic              add_start;
    logic [SUM_W-1:0]  add_result;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_result;
    mm_t               out_Mm;
    logic              busy;

    modport master (
        input  in_valid, in_nib, in_Mm, flush, add_result, out_ready,
        output in_ready, add_data, add_Mm, add_start, out_valid, out_result, out_Mm, busy
    );

    modport slave (
        output in_valid, in_nib, in_Mm, flush, add_result, out_ready,
        input  in_ready, add_data, add_Mm, add_start, out_valid, out_result, out_Mm, busy
    );
endinterface

// File: rtl/adder_operand_feeder.sv
// adder_operand_feeder: packs serial nibbles onto the adder lane bus, waits the adder latency, returns the tagged sum
module adder_operand_feeder
    import adder_operand_feeder_pkg::*;
(
    input logic                    sysclk,
    input logic                    rst_n,
    adder_operand_feeder_if.master bus
);
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [BUS_W-1:0] r_add_data;
    mm_t              r_add_Mm;
    logic             r_add_start;
    logic             r_out_valid;
    logic [SUM_W-1:0] r_out_result;
    mm_t              r_out_Mm;

    logic w_in_fire;
    logic w_last;
    logic w_capture;
    logic w_out_fire;

    assign w_in_fire  = (r_state == ST_LOAD) && !bus.flush && bus.in_valid;
    assign w_last     = w_in_fire && (r_idx == IDX_W'(N_OPS - 1));
    assign w_capture  = (r_state == ST_WAIT) && (r_lat_cnt == CNT_W'(1));
    assign w_out_fire = (r_state == ST_HOLD) && r_out_valid && bus.out_ready && !bus.flush;

    assign bus.in_ready   = (r_state == ST_LOAD) && !bus.flush;
    assign bus.busy       = (r_state == ST_WAIT) || (r_state == ST_HOLD);
    assign bus.add_data   = r_add_data;
    assign bus.add_Mm     = r_add_Mm;
    assign bus.add_start  = r_add_start;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_Mm     = r_out_Mm;

    // Sequencing: LOAD collects operands, WAIT counts the adder latency, HOLD offers the sum
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_lat_cnt   <= '0;
            r_add_start <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_LOAD;
            r_lat_cnt   <= '0;
            r_add_start <= 1'b0;
        end else begin
            r_add_start <= w_last;
            if (w_last) begin
                r_state   <= ST_WAIT;
                r_lat_cnt <= CNT_W'(ADDER_LAT);
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                if (w_capture) r_state <= ST_HOLD;
            end else if (w_out_fire) begin
                r_state <= ST_LOAD;
            end
        end
    end

    // Operand capture: lane idx takes the zero-extended nibble, operand 0 also carries Mm
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_add_data <= '0;
            r_add_Mm   <= '0;
        end else if (bus.flush) begin
            r_idx      <= '0;
            r_add_data <= '0;
        end else if (w_in_fire) begin
            r_add_data[int'(r_idx)*LANE_W +: LANE_W] <= lane_of(bus.in_nib);
            if (r_idx == '0) r_add_Mm <= bus.in_Mm;
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end else if (w_out_fire) begin
            r_add_data <= '0;
        end
    end

    // Result register: capture on the last latency edge, release on the output handshake
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_Mm     <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= bus.add_result;
            r_out_Mm     <= r_add_Mm;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_operand_feeder.sv
// tb_adder_operand_feeder: scoreboard bench driving operand transactions against a registered adder responder
module tb_adder_operand_feeder;
    import adder_operand_feeder_pkg::*;

    typedef struct {
        logic [7:0] sum;
        logic [5:0] mm;
    } exp_t;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] r_sum;

    always #5 sysclk = ~sysclk;

    adder_operand_feeder_if bus();

    adder_operand_feeder dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    function automatic logic [7:0] lane_sum(input logic [63:0] d);
        logic [7:0] s = 8'd0;
        for (int k = 0; k < 8; k++) s += d[8*k +: 8];
        return s;
    endfunction

    // adder responder: one registered stage summing the eight lanes
    always @(posedge sysclk) r_sum <= lane_sum(bus.add_data);
    assign bus.add_result = r_sum;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send_op(input logic [3:0] nib, input logic [5:0] mm, input int gap_pct);
        int n = 0;
        while (int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_nib   = nib;
        bus.in_Mm    = mm;
        @(negedge sysclk);
        while (!bus.in_ready && n < 50) begin
            @(negedge sysclk);
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL op_accept in_ready=%b required=1 after %0d cycles", bus.in_ready, n);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_txn(input logic [31:0] ops, input logic [5:0] mm, input int gap_pct, input bit push);
        logic [7:0] s = 8'd0;
        exp_t e;
        tick();
        for (int i = 0; i < 8; i++) begin
            send_op(ops[4*i +: 4], (i == 0) ? mm : ~mm, gap_pct);
            s += {4'd0, ops[4*i +: 4]};
        end
        e.sum = s;
        e.mm  = mm;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 50) begin
            @(negedge sysclk);
            if (sb.size() == 0 && !bus.busy && !bus.out_valid) break;
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL %s_idle pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), bus.busy);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.add_data, bus.add_Mm, bus.add_start} !== 71'd0) begin
            bad++;
            $display("FAIL reset_add data=%h Mm=%b start=%b required all 0", bus.add_data, bus.add_Mm, bus.add_start);
        end
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_Mm, bus.busy} !== 16'd0) begin
            bad++;
            $display("FAIL reset_out valid=%b result=%h Mm=%b busy=%b required all 0", bus.out_valid, bus.out_result, bus.out_Mm, bus.busy);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
        end
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send_txn(32'h87654321, 6'b111_000, 0, 1'b1);
        @(negedge sysclk);
        total++;
        if (bus.add_start !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_c1 add_start=%b out_valid=%b required 1/0", bus.add_start, bus.out_valid);
        end
        total++;
        if (bus.add_data !== 64'h0807060504030201 || bus.add_Mm !== 6'b111_000) begin
            bad++;
            $display("FAIL basic_bus data=%h Mm=%b required 0807060504030201/111000", bus.add_data, bus.add_Mm);
        end
        @(negedge sysclk);
        total++;
        if (bus.add_start !== 1'b0 || bus.out_valid !== 1'b0 || bus.add_data !== 64'h0807060504030201) begin
            bad++;
            $display("FAIL basic_c2 add_start=%b out_valid=%b data=%h required 0/0/0807060504030201", bus.add_start, bus.out_valid, bus.add_data);
        end
        @(negedge sysclk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 8'd36 || bus.out_Mm !== 6'b111_000) begin
            bad++;
            $display("FAIL basic_c3 valid=%b result=%0d Mm=%b required 1/36/111000", bus.out_valid, bus.out_result, bus.out_Mm);
        end
        wait_idle("basic");
    endtask

    task automatic test_all_f();
        bus.out_ready = 1'b1;
        send_txn(32'hFFFFFFFF, 6'b100_011, 0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge sysclk);
            total++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL allf_ready_c%0d in_ready=%b busy=%b required 0/1", c, bus.in_ready, bus.busy);
            end
        end
        wait_idle("allf");
    endtask

    task automatic test_stall();
        int n = 0;
        bus.out_ready = 1'b0;
        send_txn(32'h62951413, 6'b010_101, 0, 1'b1);
        @(negedge sysclk);
        while (!bus.out_valid && n < 10) begin
            @(negedge sysclk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge sysclk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 8'd31 || bus.out_Mm !== 6'b010_101) begin
                bad++;
                $display("FAIL stall_c%0d valid=%b result=%0d Mm=%b required 1/31/010101", c, bus.out_valid, bus.out_result, bus.out_Mm);
            end
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge sysclk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.add_data !== 64'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release valid=%b data=%h busy=%b in_ready=%b required 0/0/0/1", bus.out_valid, bus.add_data, bus.busy, bus.in_ready);
        end
        wait_idle("stall");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        send_txn(32'h87654321, 6'b111_000, 50, 1'b1);
        send_txn(32'h87654321, 6'b001_010, 50, 1'b1);
        wait_idle("b2b");
    endtask

    task automatic test_flush();
        int n = 0;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send_op(4'(i + 9), 6'b101_101, 0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_nib   = 4'hF;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge sysclk);
        total++;
        if (bus.add_data !== 64'd0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear data=%h in_ready=%b required 0/1", bus.add_data, bus.in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge sysclk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_no_out_c%0d out_valid=%b required 0", c, bus.out_valid);
            end
        end
        send_txn(32'h2468ACE1, 6'b011_110, 0, 1'b1);
        wait_idle("flush_load");
        bus.out_ready = 1'b0;
        send_txn(32'h11111111, 6'b110_001, 0, 1'b0);
        @(negedge sysclk);
        while (!bus.out_valid && n < 10) begin
            @(negedge sysclk);
            n++;
        end
        tick();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge sysclk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_hold valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
        end
        wait_idle("flush_hold");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send_txn(32'h55555555, 6'b010_010, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.add_data, bus.add_Mm, bus.add_start} !== 71'd0) begin
            bad++;
            $display("FAIL rstmid_add data=%h Mm=%b start=%b required all 0", bus.add_data, bus.add_Mm, bus.add_start);
        end
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_Mm, bus.busy} !== 16'd0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_out valid=%b result=%h Mm=%b busy=%b in_ready=%b required 0/0/0/0/1", bus.out_valid, bus.out_result, bus.out_Mm, bus.busy, bus.in_ready);
        end
        tick();
        tick();
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sysclk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_no_out_c%0d out_valid=%b required 0", c, bus.out_valid);
            end
        end
        send_txn(32'h87654321, 6'b000_111, 0, 1'b1);
        wait_idle("rstmid");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_nib    = '0;
        bus.in_Mm     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        fork
            forever begin
                @(negedge sysclk);
                if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected result=%0d Mm=%b required no output", bus.out_result, bus.out_Mm);
                    end else begin
                        mon_e = sb.pop_front();
                        if (bus.out_result !== mon_e.sum || bus.out_Mm !== mon_e.mm) begin
                            bad++;
                            $display("FAIL sb_result result=%0d Mm=%b required %0d/%b", bus.out_result, bus.out_Mm, mon_e.sum, mon_e.mm);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_basic();
        test_all_f();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
